// File: rtl/udm_tx_pkg.sv
// rtl/udm_tx_pkg.sv - shared types for udm_uart_tx; UDM_TX_BREAK_EN adds the BREAK state
package udm_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UDM_TX_BREAK_EN
        , ST_BREAK
`endif
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Break length in bit times is BRK_MULT * (DATA_BITS + 2)
    localparam int BRK_MULT = 2;

    // Mode 3 is an alias of "no parity"
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/udm_sync_fifo.sv
// rtl/udm_sync_fifo.sv - single-clock FIFO with full/empty/level; push ignored when full, pop when empty
module udm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_level == (AW+1)'(DEPTH));
    assign empty_o = (r_level == '0);
    assign level_o = r_level;
    assign data_o  = r_mem[r_rptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/udm_uart_tx.sv
// rtl/udm_uart_tx.sv - buffered UART transmitter with per-frame format latching
// Optional break generation (brk_req_i, BREAK state) is enabled by UDM_TX_BREAK_EN.
module udm_uart_tx
    import udm_tx_pkg::*;
#(
    parameter int DIV_WIDTH  = 32,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DIV_WIDTH-1:0]          divider_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    input  logic                          wr_req_i,
    input  logic [DATA_BITS-1:0]          wr_data_i,
`ifdef UDM_TX_BREAK_EN
    input  logic                          brk_req_i,
`endif
    output logic                          wr_ack_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int BW = $clog2(DATA_BITS);

    logic                 w_full, w_empty, w_pop, w_tc, w_frame_end;
    logic [DATA_BITS-1:0] w_head;
    logic [DIV_WIDTH-1:0] w_div_eff;

    tx_state_e            r_state;
    logic [DIV_WIDTH-1:0] r_div, r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit;
    parity_e              r_par;
    logic                 r_par_bit, r_stop2, r_second, r_tx;

    udm_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_req_i),
        .data_i  (wr_data_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    assign w_div_eff   = (divider_i == '0) ? DIV_WIDTH'(1) : divider_i;
    assign w_tc        = (r_cnt == r_div - 1'b1);
    assign w_frame_end = (r_state == ST_STOP) && w_tc && (!r_stop2 || r_second);

`ifdef UDM_TX_BREAK_EN
    localparam int BRK_BITS = BRK_MULT * (DATA_BITS + 2);
    localparam int BRKW     = $clog2(BRK_BITS);
    logic            r_brk_pend;
    logic [BRKW-1:0] r_brk_cnt;
    logic            w_brk_go, w_brk_start;
    // A break seen mid-frame is remembered and wins over the next FIFO pop
    assign w_brk_go    = brk_req_i || r_brk_pend;
    assign w_brk_start = w_brk_go && (r_state == ST_IDLE || w_frame_end);

    always_ff @(posedge clk_i) begin
        if (rst_i)            r_brk_pend <= 1'b0;
        else if (w_brk_start) r_brk_pend <= 1'b0;
        else if (brk_req_i)   r_brk_pend <= 1'b1;
    end
`else
    logic w_brk_go;
    assign w_brk_go = 1'b0;
`endif

    assign w_pop    = !w_empty && !w_brk_go && (r_state == ST_IDLE || w_frame_end);
    assign wr_ack_o = !w_full;
    assign tx_o     = r_tx;
    assign busy_o   = (r_state != ST_IDLE) || !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_div     <= DIV_WIDTH'(1);
            r_shift   <= '0;
            r_bit     <= '0;
            r_par     <= PAR_NONE;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_second  <= 1'b0;
`ifdef UDM_TX_BREAK_EN
            r_brk_cnt <= '0;
`endif
        end else begin
            r_cnt <= (r_state == ST_IDLE || w_tc) ? '0 : r_cnt + 1'b1;
            if (w_pop) begin
                // Frame format is frozen here; later input changes wait for the next frame
                r_state   <= ST_START;
                r_tx      <= 1'b0;
                r_div     <= w_div_eff;
                r_par     <= decode_parity(parity_i);
                r_par_bit <= (^w_head) ^ (decode_parity(parity_i) == PAR_ODD);
                r_stop2   <= stop2_i;
                r_shift   <= w_head;
                r_second  <= 1'b0;
            end
`ifdef UDM_TX_BREAK_EN
            else if (w_brk_start) begin
                r_state   <= ST_BREAK;
                r_tx      <= 1'b0;
                r_div     <= w_div_eff;
                r_brk_cnt <= '0;
            end
`endif
            else begin
                case (r_state)
                    ST_IDLE: r_tx <= 1'b1;
                    ST_START: if (w_tc) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                    end
                    ST_DATA: if (w_tc) begin
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_state <= (r_par != PAR_NONE) ? ST_PARITY : ST_STOP;
                            r_tx    <= (r_par != PAR_NONE) ? r_par_bit : 1'b1;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                    ST_PARITY: if (w_tc) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                    ST_STOP: if (w_tc) begin
                        if (r_stop2 && !r_second) r_second <= 1'b1;
                        else                      r_state  <= ST_IDLE;
                    end
`ifdef UDM_TX_BREAK_EN
                    ST_BREAK: if (w_tc) begin
                        if (r_brk_cnt == BRKW'(BRK_BITS - 1)) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_brk_cnt <= r_brk_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udm_uart_tx.sv
// tb/tb_udm_uart_tx.sv - self-checking bench for udm_uart_tx; break test built with UDM_TX_BREAK_EN
module tb_udm_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [1:0] par;
        bit         stop2;
        bit         brk;
    } frm_t;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [1:0] par;
        bit         stop2;
        int         len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] divider_i = 32'd4;
    logic [1:0]  parity_i = 2'd0;
    logic        stop2_i = 1'b0;
    logic        wr_req_i = 1'b0;
    logic [7:0]  wr_data_i = 8'h00;
`ifdef UDM_TX_BREAK_EN
    logic        brk_req_i = 1'b0;
`endif
    logic        wr_ack_o, tx_o, busy_o;
    logic [4:0]  level_o;

    int   n_pass = 0, n_chk = 0;
    int   cyc = 0, last_acc = 0, frames_seen = 0;
    bit   ack_low_seen = 0;
    int   lvl_at_low = -1;
    frm_t sb[$];
    vec_t vt[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    udm_uart_tx dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .divider_i (divider_i),
        .parity_i  (parity_i),
        .stop2_i   (stop2_i),
        .wr_req_i  (wr_req_i),
        .wr_data_i (wr_data_i),
`ifdef UDM_TX_BREAK_EN
        .brk_req_i (brk_req_i),
`endif
        .wr_ack_o  (wr_ack_o),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .level_o   (level_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Called at posedge+#1; expected frame format is what the DUT should latch at pop time
    task automatic wr(input logic [7:0] d, input int ediv);
        bit acc;
        bit done;
        frm_t e;
        done = 0;
        wr_req_i  = 1'b1;
        wr_data_i = d;
        for (int t = 0; t < 5000 && !done; t++) begin
            acc = wr_ack_o;
            if (!acc) begin
                ack_low_seen = 1;
                lvl_at_low   = int'(level_o);
            end
            @(posedge clk); #1;
            if (acc) done = 1;
        end
        wr_req_i = 1'b0;
        if (!done) chk("wr_accept_timeout", 0, 1);
        e.data = d; e.div = ediv; e.par = parity_i; e.stop2 = stop2_i; e.brk = 0;
        sb.push_back(e);
        last_acc = cyc;
    endtask

    task automatic wait_idle(input int t0, input int exp, input string nm);
        for (int i = 0; i < 3000 && busy_o; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, cyc - t0, exp);
    endtask

    // Line monitor: every cycle of each expected frame must carry the expected level
    initial begin : monitor
        frm_t e;
        bit   bits [32];
        int   nb, bad;
        bit   ab;
        forever begin
            @(negedge clk);
            if (!rst_i && tx_o === 1'b0) begin
                frames_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_frame", frames_seen, 0);
                end else begin
                    e = sb.pop_front();
                    if (e.brk) begin
                        nb = 2 * (8 + 2);
                        for (int i = 0; i < nb; i++) bits[i] = 1'b0;
                    end else begin
                        bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
                        nb = 9;
                        if (e.par == 2'd1 || e.par == 2'd2) begin
                            bits[nb] = (^e.data) ^ (e.par == 2'd2);
                            nb++;
                        end
                        bits[nb] = 1'b1; nb++;
                        if (e.stop2) begin bits[nb] = 1'b1; nb++; end
                    end
                    bad = 0; ab = 0;
                    for (int b = 0; b < nb; b++) begin
                        for (int c = 0; c < e.div; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (rst_i) ab = 1;
                            else if (!ab && tx_o !== bits[b]) bad++;
                        end
                    end
                    if (!ab) chk($sformatf("frame_%02h_brk%0d_bad_cycles", e.data, e.brk), bad, 0);
                end
            end
        end
    end

    initial begin : main
        int t0, fs, low;
        vt[0] = '{8'h55, 4, 2'd0, 1'b0, 40};
        vt[1] = '{8'hA3, 3, 2'd1, 1'b0, 33};
        vt[2] = '{8'hA3, 3, 2'd2, 1'b0, 33};
        vt[3] = '{8'h00, 0, 2'd0, 1'b1, 11};
        vt[4] = '{8'hFF, 2, 2'd3, 1'b1, 22};
        vt[5] = '{8'h3C, 5, 2'd2, 1'b1, 60};

        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("reset_tx", tx_o, 1);
        chk("reset_busy", busy_o, 0);
        chk("reset_level", level_o, 0);
        chk("reset_ack", wr_ack_o, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            divider_i = vt[i].div;
            parity_i  = vt[i].par;
            stop2_i   = vt[i].stop2;
            wr(vt[i].data, (vt[i].div == 0) ? 1 : vt[i].div);
            t0 = last_acc;
            chk($sformatf("row%0d_tx_before_start", i), tx_o, 1);
            chk($sformatf("row%0d_level", i), level_o, 1);
            @(posedge clk); #1;
            chk($sformatf("row%0d_tx_start", i), tx_o, 0);
            wait_idle(t0, vt[i].len + 1, $sformatf("row%0d_busy_cycles", i));
            chk($sformatf("row%0d_tx_idle", i), tx_o, 1);
            repeat (3) @(posedge clk); #1;
        end

        // Burst of 20 at div=2: FIFO fills, frames must run back-to-back
        divider_i = 2; parity_i = 0; stop2_i = 0;
        ack_low_seen = 0;
        wr(8'h05, 2);
        t0 = last_acc;
        for (int i = 1; i < 20; i++) wr(8'(i * 37 + 5), 2);
        chk("burst_ack_dropped", ack_low_seen, 1);
        chk("burst_level_at_ack_low", lvl_at_low, 16);
        wait_idle(t0, 20 * 20 + 1, "burst_busy_cycles");
        repeat (3) @(posedge clk); #1;

        // Divider change mid-frame applies to the next frame only
        divider_i = 4;
        wr(8'h5A, 4);
        t0 = last_acc;
        wr(8'hC3, 8);
        repeat (6) @(posedge clk); #1;
        divider_i = 8;
        wait_idle(t0, 1 + 40 + 80, "divchg_busy_cycles");
        repeat (3) @(posedge clk); #1;

        // Reset mid-frame with bytes queued
        divider_i = 4;
        for (int i = 0; i < 5; i++) wr(8'(8'h11 * (i + 1)), 4);
        repeat (10) @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        sb.delete();
        chk("rst_tx", tx_o, 1);
        chk("rst_level", level_o, 0);
        chk("rst_busy", busy_o, 0);
        fs = frames_seen; low = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx_o !== 1'b1) low++;
        end
        chk("rst_no_new_frames", frames_seen - fs, 0);
        chk("rst_line_idle_cycles_low", low, 0);

`ifdef UDM_TX_BREAK_EN
        begin
            frm_t be;
            divider_i = 2;
            wr(8'h81, 2);
            t0 = last_acc;
            wr(8'h7E, 2);
            repeat (4) @(posedge clk); #1;
            brk_req_i = 1'b1;
            be.data = 8'h00; be.div = 2; be.par = 2'd0; be.stop2 = 1'b0; be.brk = 1'b1;
            sb.push_front(be);
            @(posedge clk); #1;
            brk_req_i = 1'b0;
            wait_idle(t0, 20 + 40 + 1 + 20 + 1, "break_busy_cycles");
            repeat (3) @(posedge clk); #1;
        end
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
